mem_bus_arbiter: RTL and testbench

- Sits directly downstream of the icache and the dcache, and directly upstream of the single-ported main memory.
- Replaces the current combinational dcache-first mux.
- Each cycle, grants the memory command port to one requester, using dcache priority with a starvation override for the icache.
- Records which requester owns each outstanding load tag, and routes each returning tag/data back only to that owner.

---
 rtl/mem_bus_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Grants the single-ported main memory command port to the
//                icache or dcache (dcache priority, starvation override for
//                the icache), tracks which requester owns each outstanding
//                load tag and routes returning tag/data only to its owner.
//                Optional statistics counters: define MEM_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int N_TAGS       = 16,
    parameter int STARVE_LIMIT = 8,
    localparam int c_TAG_W     = $clog2(N_TAGS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         icache2arb_command,
    input  logic [XLEN-1:0]    icache2arb_addr,
    input  logic [1:0]         dcache2arb_command,
    input  logic [XLEN-1:0]    dcache2arb_addr,
    input  logic [63:0]        dcache2arb_data,
    input  logic [c_TAG_W-1:0] mem2arb_response,
    input  logic [63:0]        mem2arb_data,
    input  logic [c_TAG_W-1:0] mem2arb_tag,
    output logic [1:0]         arb2mem_command,
    output logic [XLEN-1:0]    arb2mem_addr,
    output logic [63:0]        arb2mem_data,
    output logic [c_TAG_W-1:0] arb2icache_response,
    output logic [c_TAG_W-1:0] arb2icache_tag,
    output logic [63:0]        arb2icache_data,
    output logic [c_TAG_W-1:0] arb2dcache_response,
    output logic [c_TAG_W-1:0] arb2dcache_tag,
    output logic [63:0]        arb2dcache_data,
    output logic               icache_grant,
    output logic [c_TAG_W:0]   outstanding_count,
    output logic               tag_error
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]        icache_accept_cnt,
    output logic [31:0]        dcache_accept_cnt,
    output logic [31:0]        starve_override_cnt
`endif
);

    localparam logic [1:0] c_BUS_NONE  = 2'd0;
    localparam logic [1:0] c_BUS_LOAD  = 2'd1;
    localparam logic [1:0] c_BUS_STORE = 2'd2;

    localparam int                  c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    // Owner table: bit i of r_valid/r_owner describes tag i; owner 1 = dcache.
    // Entry 0 is never allocated so a zero tag always reads as "no entry".
    logic [N_TAGS-1:0]     r_valid;
    logic [N_TAGS-1:0]     r_owner;
    logic [N_TAGS-1:0]     w_valid_nxt;
    logic [N_TAGS-1:0]     w_owner_nxt;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic [c_TAG_W:0]      r_count;
    logic [c_TAG_W:0]      w_pop;
    logic                  r_tag_error;

    logic w_i_req;
    logic w_d_req;
    logic w_starve_flag;
    logic w_grant_i;
    logic w_grant_d;
    logic w_accepted;
    logic w_alloc;
    logic w_ret_hit;
    logic w_ret_miss;
    logic w_overwrite;

    // The icache can only load; a store from it is ignored entirely.
    assign w_i_req       = (icache2arb_command == c_BUS_LOAD);
    assign w_d_req       = (dcache2arb_command == c_BUS_LOAD) ||
                           (dcache2arb_command == c_BUS_STORE);
    assign w_starve_flag = (r_starve_cnt == c_STARVE_MAX);
    assign w_grant_i     = w_i_req && (!w_d_req || w_starve_flag);
    assign w_grant_d     = w_d_req && !w_grant_i;
    assign w_accepted    = (mem2arb_response != '0);

    // Same-cycle command mux: memory sees the winner with no added latency.
    always_comb begin
        arb2mem_command = c_BUS_NONE;
        arb2mem_addr    = '0;
        if (w_grant_i) begin
            arb2mem_command = c_BUS_LOAD;
            arb2mem_addr    = icache2arb_addr;
        end else if (w_grant_d) begin
            arb2mem_command = dcache2arb_command;
            arb2mem_addr    = dcache2arb_addr;
        end
    end

    assign arb2mem_data        = dcache2arb_data;
    assign icache_grant        = w_grant_i;
    assign arb2icache_response = w_grant_i ? mem2arb_response : '0;
    assign arb2dcache_response = w_grant_d ? mem2arb_response : '0;

    // Only accepted loads create ownership; stores never come back.
    assign w_alloc     = w_accepted && (arb2mem_command == c_BUS_LOAD);
    assign w_ret_hit   = (mem2arb_tag != '0) &&  r_valid[mem2arb_tag];
    assign w_ret_miss  = (mem2arb_tag != '0) && !r_valid[mem2arb_tag];
    // Reusing a tag that is retiring in this same cycle is legitimate.
    assign w_overwrite = w_alloc && r_valid[mem2arb_response] &&
                         !(w_ret_hit && (mem2arb_tag == mem2arb_response));

    // Return routing uses the table as it stood before this edge.
    always_comb begin
        arb2icache_tag  = '0;
        arb2icache_data = '0;
        arb2dcache_tag  = '0;
        arb2dcache_data = '0;
        if (w_ret_hit) begin
            if (r_owner[mem2arb_tag]) begin
                arb2dcache_tag  = mem2arb_tag;
                arb2dcache_data = mem2arb_data;
            end else begin
                arb2icache_tag  = mem2arb_tag;
                arb2icache_data = mem2arb_data;
            end
        end
    end

    // Next table contents: retire first, then allocate so allocation wins.
    always_comb begin
        w_valid_nxt = r_valid;
        w_owner_nxt = r_owner;
        if (w_ret_hit) begin
            w_valid_nxt[mem2arb_tag] = 1'b0;
        end
        if (w_alloc) begin
            w_valid_nxt[mem2arb_response] = 1'b1;
            w_owner_nxt[mem2arb_response] = w_grant_d;
        end
        w_valid_nxt[0] = 1'b0;
        w_owner_nxt[0] = 1'b0;
    end

    // Popcount of the next table so the registered count tracks the table.
    always_comb begin
        w_pop = '0;
        for (int i = 1; i < N_TAGS; i++) begin
            w_pop = w_pop + {{c_TAG_W{1'b0}}, w_valid_nxt[i]};
        end
    end

    // Owner table, outstanding count and sticky tag error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= '0;
            r_owner     <= '0;
            r_count     <= '0;
            r_tag_error <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_owner <= w_owner_nxt;
            r_count <= w_pop;
            if (w_ret_miss || w_overwrite) begin
                r_tag_error <= 1'b1;
            end
        end
    end

    // Starvation counter: counts denied icache cycles, holds on a rejected
    // grant so a forced grant stays forced until memory takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!w_i_req) begin
            r_starve_cnt <= '0;
        end else if (w_grant_i) begin
            if (w_accepted) begin
                r_starve_cnt <= '0;
            end
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign outstanding_count = r_count;
    assign tag_error         = r_tag_error;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_i_acc_cnt;
    logic [31:0] r_d_acc_cnt;
    logic [31:0] r_ovr_cnt;

    // Saturating event counters for performance visibility.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_i_acc_cnt <= '0;
            r_d_acc_cnt <= '0;
            r_ovr_cnt   <= '0;
        end else begin
            if (w_grant_i && w_accepted && (r_i_acc_cnt != '1)) begin
                r_i_acc_cnt <= r_i_acc_cnt + 32'd1;
            end
            if (w_grant_d && w_accepted && (r_d_acc_cnt != '1)) begin
                r_d_acc_cnt <= r_d_acc_cnt + 32'd1;
            end
            if (w_starve_flag && w_i_req && w_d_req && (r_ovr_cnt != '1)) begin
                r_ovr_cnt <= r_ovr_cnt + 32'd1;
            end
        end
    end

    assign icache_accept_cnt   = r_i_acc_cnt;
    assign dcache_accept_cnt   = r_d_acc_cnt;
    assign starve_override_cnt = r_ovr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed scoreboard bench for mem_bus_arbiter. Stimulus
//                queues hand-computed expectations tagged with the cycle;
//                a monitor on the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam logic [1:0] c_NONE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_STORE = 2'd2;

    localparam int c_S_GRANT = 0;
    localparam int c_S_CMD   = 1;
    localparam int c_S_ADDR  = 2;
    localparam int c_S_IRESP = 3;
    localparam int c_S_DRESP = 4;
    localparam int c_S_ITAG  = 5;
    localparam int c_S_IDATA = 6;
    localparam int c_S_DTAG  = 7;
    localparam int c_S_DDATA = 8;
    localparam int c_S_OUTST = 9;
    localparam int c_S_TERR  = 10;
    localparam int c_S_IACC  = 11;
    localparam int c_S_DACC  = 12;
    localparam int c_S_OVR   = 13;
    localparam int c_S_MDATA = 14;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache2arb_command;
    logic [31:0] icache2arb_addr;
    logic [1:0]  dcache2arb_command;
    logic [31:0] dcache2arb_addr;
    logic [63:0] dcache2arb_data;
    logic [3:0]  mem2arb_response;
    logic [63:0] mem2arb_data;
    logic [3:0]  mem2arb_tag;
    logic [1:0]  arb2mem_command;
    logic [31:0] arb2mem_addr;
    logic [63:0] arb2mem_data;
    logic [3:0]  arb2icache_response;
    logic [3:0]  arb2icache_tag;
    logic [63:0] arb2icache_data;
    logic [3:0]  arb2dcache_response;
    logic [3:0]  arb2dcache_tag;
    logic [63:0] arb2dcache_data;
    logic        icache_grant;
    logic [4:0]  outstanding_count;
    logic        tag_error;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icache_accept_cnt;
    logic [31:0] dcache_accept_cnt;
    logic [31:0] starve_override_cnt;
`endif

    mem_bus_arbiter dut (
        .clock               (clock),
        .reset               (reset),
        .icache2arb_command  (icache2arb_command),
        .icache2arb_addr     (icache2arb_addr),
        .dcache2arb_command  (dcache2arb_command),
        .dcache2arb_addr     (dcache2arb_addr),
        .dcache2arb_data     (dcache2arb_data),
        .mem2arb_response    (mem2arb_response),
        .mem2arb_data        (mem2arb_data),
        .mem2arb_tag         (mem2arb_tag),
        .arb2mem_command     (arb2mem_command),
        .arb2mem_addr        (arb2mem_addr),
        .arb2mem_data        (arb2mem_data),
        .arb2icache_response (arb2icache_response),
        .arb2icache_tag      (arb2icache_tag),
        .arb2icache_data     (arb2icache_data),
        .arb2dcache_response (arb2dcache_response),
        .arb2dcache_tag      (arb2dcache_tag),
        .arb2dcache_data     (arb2dcache_data),
        .icache_grant        (icache_grant),
        .outstanding_count   (outstanding_count),
        .tag_error           (tag_error)
`ifdef MEM_ARB_STATS_EN
        ,
        .icache_accept_cnt   (icache_accept_cnt),
        .dcache_accept_cnt   (dcache_accept_cnt),
        .starve_override_cnt (starve_override_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Cycle stamp advanced on every rising edge.
    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    function automatic logic [63:0] sample(input int sig);
        logic [63:0] v;
        v = '0;
        case (sig)
            c_S_GRANT: v = {63'd0, icache_grant};
            c_S_CMD:   v = {62'd0, arb2mem_command};
            c_S_ADDR:  v = {32'd0, arb2mem_addr};
            c_S_IRESP: v = {60'd0, arb2icache_response};
            c_S_DRESP: v = {60'd0, arb2dcache_response};
            c_S_ITAG:  v = {60'd0, arb2icache_tag};
            c_S_IDATA: v = arb2icache_data;
            c_S_DTAG:  v = {60'd0, arb2dcache_tag};
            c_S_DDATA: v = arb2dcache_data;
            c_S_OUTST: v = {59'd0, outstanding_count};
            c_S_TERR:  v = {63'd0, tag_error};
            c_S_MDATA: v = arb2mem_data;
`ifdef MEM_ARB_STATS_EN
            c_S_IACC:  v = {32'd0, icache_accept_cnt};
            c_S_DACC:  v = {32'd0, dcache_accept_cnt};
            c_S_OVR:   v = {32'd0, starve_override_cnt};
`endif
            default:   v = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return v;
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    initial forever begin
        @(negedge clock);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [63:0] got;
            e     = sb.pop_front();
            total = total + 1;
            if (e.cyc < cyc) begin
                bad = bad + 1;
                $display("FAIL %s: check from cycle %0d never sampled", e.nm, e.cyc);
            end else begin
                got = sample(e.sig);
                if (got !== e.exp) begin
                    bad = bad + 1;
                    $display("FAIL %s (cycle %0d): got %0h expected %0h", e.nm, e.cyc, got, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.exp = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        icache2arb_command = c_NONE;
        icache2arb_addr    = '0;
        dcache2arb_command = c_NONE;
        dcache2arb_addr    = '0;
        dcache2arb_data    = '0;
        mem2arb_response   = '0;
        mem2arb_data       = '0;
        mem2arb_tag        = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_v(c_S_OUTST, 64'd0, "reset_outstanding");
        expect_v(c_S_TERR,  64'd0, "reset_tag_error");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        logic [3:0]  rsp;
        logic        ig;

        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        expect_v(c_S_OUTST, 64'd0, "init_outstanding");
        expect_v(c_S_TERR,  64'd0, "init_tag_error");
        expect_v(c_S_GRANT, 64'd0, "init_grant");
        expect_v(c_S_CMD,   64'd0, "init_cmd");
        expect_v(c_S_ADDR,  64'd0, "init_addr");

        // Both caches load every cycle; memory accepts with tags 1,2,3,...
        for (int k = 1; k <= 18; k++) begin
            step();
            ia  = 32'h1000_0000 + 32'(k * 4);
            da  = 32'h2000_0000 + 32'(k * 8);
            rsp = 4'(((k - 1) % 15) + 1);
            ig  = (k == 9) || (k == 18);
            icache2arb_command = c_LOAD;
            icache2arb_addr    = ia;
            dcache2arb_command = c_LOAD;
            dcache2arb_addr    = da;
            mem2arb_response   = rsp;
            expect_v(c_S_GRANT, {63'd0, ig}, "starve_grant");
            expect_v(c_S_ADDR,  {32'd0, ig ? ia : da}, "starve_addr");
            expect_v(c_S_IRESP, {60'd0, ig ? rsp : 4'd0}, "starve_iresp");
            expect_v(c_S_DRESP, {60'd0, ig ? 4'd0 : rsp}, "starve_dresp");
        end
        step();
        idle();
        expect_v(c_S_OUTST, 64'd15, "full_table_count");
        expect_v(c_S_TERR,  64'd1,  "overwrite_tag_error");
        expect_v(c_S_CMD,   64'd0,  "idle_cmd");
        expect_v(c_S_ADDR,  64'd0,  "idle_addr");
`ifdef MEM_ARB_STATS_EN
        expect_v(c_S_IACC, 64'd2,  "stats_icache_accept");
        expect_v(c_S_DACC, 64'd16, "stats_dcache_accept");
        expect_v(c_S_OVR,  64'd2,  "stats_override");
`endif
        do_reset();

        // Dcache load with tag 5, returned ten cycles later.
        step();
        dcache2arb_command = c_LOAD;
        dcache2arb_addr    = 32'h0000_4000;
        mem2arb_response   = 4'd5;
        expect_v(c_S_DRESP, 64'd5, "d5_dresp");
        expect_v(c_S_IRESP, 64'd0, "d5_iresp");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd1, "d5_count_one");
        for (int k = 0; k < 9; k++) begin
            step();
        end
        mem2arb_tag  = 4'd5;
        mem2arb_data = 64'hDEAD_BEEF_0123_4567;
        expect_v(c_S_DTAG,  64'd5, "d5_ret_dtag");
        expect_v(c_S_DDATA, 64'hDEAD_BEEF_0123_4567, "d5_ret_ddata");
        expect_v(c_S_ITAG,  64'd0, "d5_ret_itag");
        expect_v(c_S_IDATA, 64'd0, "d5_ret_idata");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd0, "d5_count_zero");
        expect_v(c_S_TERR,  64'd0, "d5_no_error");

        // Dcache store with tag 3 creates no entry.
        step();
        dcache2arb_command = c_STORE;
        dcache2arb_addr    = 32'h0000_8000;
        dcache2arb_data    = 64'h1122_3344_5566_7788;
        mem2arb_response   = 4'd3;
        expect_v(c_S_CMD,   {62'd0, c_STORE}, "st_cmd");
        expect_v(c_S_MDATA, 64'h1122_3344_5566_7788, "st_data");
        expect_v(c_S_DRESP, 64'd3, "st_dresp");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd0, "st_count_zero");
        step();
        mem2arb_tag  = 4'd3;
        mem2arb_data = 64'h0BAD;
        expect_v(c_S_ITAG, 64'd0, "st_ret_itag");
        expect_v(c_S_DTAG, 64'd0, "st_ret_dtag");
        step();
        idle();
        expect_v(c_S_TERR, 64'd1, "st_tag_error");
        do_reset();

        // Tag 7 returns to the icache while a dcache load reuses tag 7.
        step();
        icache2arb_command = c_LOAD;
        icache2arb_addr    = 32'h0000_0700;
        mem2arb_response   = 4'd7;
        expect_v(c_S_GRANT, 64'd1, "t7_igrant");
        expect_v(c_S_IRESP, 64'd7, "t7_iresp");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd1, "t7_count");
        step();
        mem2arb_tag        = 4'd7;
        mem2arb_data       = 64'hCAFE_0000_0000_0007;
        dcache2arb_command = c_LOAD;
        dcache2arb_addr    = 32'h0000_0770;
        mem2arb_response   = 4'd7;
        expect_v(c_S_ITAG,  64'd7, "t7_ret_itag");
        expect_v(c_S_IDATA, 64'hCAFE_0000_0000_0007, "t7_ret_idata");
        expect_v(c_S_DTAG,  64'd0, "t7_ret_dtag");
        expect_v(c_S_DRESP, 64'd7, "t7_realloc_dresp");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd1, "t7_count_unchanged");
        expect_v(c_S_TERR,  64'd0, "t7_no_error");
        step();
        mem2arb_tag  = 4'd7;
        mem2arb_data = 64'h0000_BEEF_0000_0077;
        expect_v(c_S_DTAG,  64'd7, "t7_second_dtag");
        expect_v(c_S_DDATA, 64'h0000_BEEF_0000_0077, "t7_second_ddata");
        expect_v(c_S_ITAG,  64'd0, "t7_second_itag");
        step();
        idle();
        expect_v(c_S_OUTST, 64'd0, "t7_count_zero");

        // Fifteen icache loads outstanding, then reset drops all ownership.
        for (int k = 1; k <= 15; k++) begin
            step();
            icache2arb_command = c_LOAD;
            icache2arb_addr    = 32'h0001_0000 + 32'(k * 4);
            mem2arb_response   = 4'(k);
        end
        step();
        idle();
        expect_v(c_S_OUTST, 64'd15, "fill_count");
        do_reset();
        step();
        mem2arb_tag  = 4'd4;
        mem2arb_data = 64'h4444;
        expect_v(c_S_ITAG, 64'd0, "late_itag");
        expect_v(c_S_DTAG, 64'd0, "late_dtag");
        step();
        idle();
        expect_v(c_S_TERR, 64'd1, "late_tag_error");

        step();
        step();
        if (sb.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d checks left unsampled", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
